// File: rtl/pbus_pkg.sv
// pbus_pkg: state encoding and default timing shared by the parallel-bus transmit and receive sides.
package pbus_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RELEASE, ABORT} pbus_state_t;
  localparam int DEF_SETUP_CYCLES = 2;
  localparam int DEF_TIMEOUT_CYCLES = 255;
endpackage

// File: rtl/pbus_tx_sync2.sv
// sync2: two-flop synchronizer for a single asynchronous control input.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/pbus_tx.sv
// pbus_tx: four-phase strobe/ack parallel-bus byte transmitter with setup delay and ack timeout.
module pbus_tx
  import pbus_pkg::*;
#(
  parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk_50Mhz,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] bus_data,
  output logic       bus_oe,
  output logic       bus_stb,
  input  logic       bus_ack,
  output logic       done,
  output logic       err
);
  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT_CYCLES - 1);
  pbus_state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       ack_s, seen_low, seen_nx, done_nx, load;
  sync2 u_ack_sync (.clk(clk_50Mhz), .rst_n(rst_n), .d(bus_ack), .q(ack_s));
  assign bus_oe  = state == SETUP || state == STROBE || state == RELEASE;
  assign bus_stb = state == STROBE;
  assign err     = state == ABORT;
  always_ff @(posedge clk_50Mhz or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      seen_low <= 1'b0;
      done     <= 1'b0;
      tx_ready <= 1'b0;
      bus_data <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      seen_low <= seen_nx;
      done     <= done_nx;
      tx_ready <= state_nx == IDLE;
      if (load) bus_data <= tx_data;
    end
  // seen_low guards against a stale ack left high from before the strobe
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    seen_nx  = seen_low;
    done_nx  = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE: if (tx_valid && tx_ready) begin
        state_nx = SETUP;
        cnt_nx   = '0;
        load     = 1'b1;
      end
      SETUP: if (cnt == SETUP_LAST) begin
        state_nx = STROBE;
        cnt_nx   = '0;
        seen_nx  = 1'b0;
      end else cnt_nx = cnt + 8'd1;
      STROBE: begin
        seen_nx = seen_low | ~ack_s;
        if (ack_s && seen_low) begin
          state_nx = RELEASE;
          cnt_nx   = '0;
        end else if (cnt == WAIT_LAST) state_nx = ABORT;
        else cnt_nx = cnt + 8'd1;
      end
      RELEASE: if (!ack_s) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end else if (cnt == WAIT_LAST) state_nx = ABORT;
      else cnt_nx = cnt + 8'd1;
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_pbus_tx.sv
// tb_pbus_tx: scoreboard bench for pbus_tx with a behavioural four-phase receiver.
module tb_pbus_tx;
  import pbus_pkg::*;
  logic       clk_50Mhz = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, bus_oe, bus_stb, done, err;
  logic [7:0] bus_data;
  logic       bus_ack = 1'b0;
  logic       resp_on = 1'b0;
  int         checks = 0;
  int         errors = 0;
  typedef struct { logic [7:0] data; bit is_err; } exp_t;
  exp_t sb[$];

  pbus_tx dut (
    .clk_50Mhz(clk_50Mhz), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .bus_data(bus_data), .bus_oe(bus_oe), .bus_stb(bus_stb),
    .bus_ack(bus_ack), .done(done), .err(err)
  );

  always #10 clk_50Mhz = ~clk_50Mhz;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk_50Mhz)
    if (rst_n && (done || err)) begin
      check("done_err_excl", 32'(done && err), 0);
      if (sb.size() == 0) check("sb_unexpected", 1, 0);
      else begin
        automatic exp_t e = sb.pop_front();
        check("sb_kind_err", 32'(err), 32'(e.is_err));
        if (done) check("sb_data", 32'(bus_data), 32'(e.data));
      end
    end

  initial forever begin
    @(negedge clk_50Mhz);
    if (resp_on && bus_stb) begin
      automatic int n = 0;
      repeat (2) @(negedge clk_50Mhz);
      bus_ack = 1'b1;
      while (bus_stb && n < 600) begin
        @(negedge clk_50Mhz);
        n++;
      end
      repeat (3) @(negedge clk_50Mhz);
      bus_ack = 1'b0;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!tx_ready && n < 50) begin
      @(negedge clk_50Mhz);
      n++;
    end
    check(tag, 32'(tx_ready), 1);
  endtask

  task automatic send(input logic [7:0] d, input bit exp_err, input bit hold);
    wait_ready("send_ready");
    tx_data  = d;
    tx_valid = 1'b1;
    sb.push_back('{d, exp_err});
    @(negedge clk_50Mhz);
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_stb(input string tag, input logic lvl);
    int n = 0;
    while (bus_stb !== lvl && n < 40) begin
      @(negedge clk_50Mhz);
      n++;
    end
    check(tag, 32'(bus_stb), 32'(lvl));
  endtask

  task automatic wait_done(input string tag, input logic [7:0] hold_val, output bit got);
    int n = 0;
    bit ok = 1'b1;
    while (!(done || err) && n < 200) begin
      if (!(bus_oe && bus_data == hold_val)) ok = 1'b0;
      @(negedge clk_50Mhz);
      n++;
    end
    got = done;
    check(tag, 32'(ok), 1);
  endtask

  initial begin
    bit got;
    int n;
    logic [7:0] b2b [3] = '{8'h01, 8'h02, 8'hFF};
    repeat (3) @(negedge clk_50Mhz);
    check("rst_ready", 32'(tx_ready), 0);
    check("rst_oe", 32'(bus_oe), 0);
    check("rst_stb", 32'(bus_stb), 0);
    check("rst_data", 32'(bus_data), 0);
    check("rst_done_err", 32'({done, err}), 0);
    rst_n = 1'b1;
    #1 check("ready_pre_edge", 32'(tx_ready), 0);
    @(negedge clk_50Mhz);
    check("ready_first_edge", 32'(tx_ready), 1);

    resp_on = 1'b1;
    send(8'hA5, 1'b0, 1'b0);
    check("a5_oe", 32'(bus_oe), 1);
    check("a5_data", 32'(bus_data), 32'hA5);
    check("a5_setup1_stb", 32'(bus_stb), 0);
    @(negedge clk_50Mhz);
    check("a5_setup2_stb", 32'(bus_stb), 0);
    @(negedge clk_50Mhz);
    check("a5_stb_rise", 32'(bus_stb), 1);
    wait_done("a5_hold", 8'hA5, got);
    check("a5_done", 32'(got), 1);

    resp_on = 1'b0;
    send(8'h5A, 1'b1, 1'b0);
    wait_stb("to_stb_rise", 1'b1);
    n = 0;
    while (!err && n < 400) begin
      @(negedge clk_50Mhz);
      n++;
    end
    check("to_cycles", 32'(n), 32'(DEF_TIMEOUT_CYCLES));
    check("to_oe_stb", 32'({bus_oe, bus_stb}), 0);
    @(negedge clk_50Mhz);
    check("to_ready", 32'(tx_ready), 1);
    check("to_err_one", 32'(err), 0);

    bus_ack = 1'b1;
    repeat (4) @(negedge clk_50Mhz);
    send(8'h77, 1'b0, 1'b0);
    wait_stb("stale_stb_rise", 1'b1);
    repeat (10) @(negedge clk_50Mhz);
    check("stale_stb_held", 32'(bus_stb), 1);
    check("stale_no_done", 32'(done), 0);
    bus_ack = 1'b0;
    repeat (4) @(negedge clk_50Mhz);
    check("stale_low_stb", 32'(bus_stb), 1);
    bus_ack = 1'b1;
    wait_stb("stale_stb_fall", 1'b0);
    bus_ack = 1'b0;
    wait_done("stale_hold", 8'h77, got);
    check("stale_done", 32'(got), 1);

    resp_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ready("b2b_ready");
      tx_data  = b2b[i];
      tx_valid = 1'b1;
      sb.push_back('{b2b[i], 1'b0});
      @(negedge clk_50Mhz);
      if (i == 2) tx_valid = 1'b0;
      wait_done("b2b_hold", b2b[i], got);
      check("b2b_done", 32'(got), 1);
      check("b2b_idle_gap", 32'({bus_oe, tx_ready}), 32'b01);
    end

    resp_on = 1'b0;
    send(8'h3C, 1'b0, 1'b0);
    wait_stb("rst_mid_stb", 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_stb", 32'(bus_stb), 0);
    check("rst_async_oe", 32'(bus_oe), 0);
    check("rst_async_data", 32'(bus_data), 0);
    check("rst_async_flags", 32'({done, err, tx_ready}), 0);
    sb.delete();
    repeat (2) @(negedge clk_50Mhz);
    rst_n = 1'b1;
    resp_on = 1'b1;
    send(8'hC3, 1'b0, 1'b0);
    wait_done("c3_hold", 8'hC3, got);
    check("c3_done", 32'(got), 1);

    send(8'h96, 1'b0, 1'b0);
    wait_stb("rel_stb_rise", 1'b1);
    wait_stb("rel_stb_fall", 1'b0);
    tx_data  = 8'h69;
    tx_valid = 1'b1;
    @(negedge clk_50Mhz);
    tx_valid = 1'b0;
    wait_done("rel_hold", 8'h96, got);
    check("rel_done", 32'(got), 1);
    repeat (4) @(negedge clk_50Mhz);
    check("rel_no_spurious", 32'({bus_oe, bus_data}), 32'h096);

    check("sb_left", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
